// File: rtl/cpu_pkg.sv
// Shared types and instruction-field constants for the fetch front end.
package cpu_pkg;

    localparam int unsigned PC_WIDTH    = 12;
    localparam int unsigned INSTR_WIDTH = 16;
    localparam int unsigned CNT_WIDTH   = 8;

    typedef logic [PC_WIDTH-1:0]    pc_t;
    typedef logic [INSTR_WIDTH-1:0] instr_t;

    localparam logic [1:0] OP_BRANCH = 2'd2;

    typedef enum logic [1:0] {
        COND_ZERO = 2'd0,
        COND_ONE  = 2'd1,
        COND_TWO  = 2'd2
    } cond_e;

    localparam int unsigned OPC_LSB    = 0;
    localparam int unsigned OPC_MSB    = 1;
    localparam int unsigned COND_LSB   = 2;
    localparam int unsigned COND_MSB   = 3;
    localparam int unsigned TARGET_LSB = 4;
    localparam int unsigned TARGET_MSB = 15;

    function automatic logic [1:0] instr_opcode(input instr_t i);
        return i[OPC_MSB:OPC_LSB];
    endfunction

    function automatic pc_t instr_target(input instr_t i);
        return i[TARGET_MSB:TARGET_LSB];
    endfunction

endpackage

// File: rtl/fetch_sequencer_instr_buffer.sv
// One-entry valid/ready holding register for fetched instructions.
module instr_buffer #(
    parameter int unsigned PC_W    = 12,
    parameter int unsigned INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               consume,
    input  logic               flush,
    input  logic [INSTR_W-1:0] load_instr,
    input  logic [PC_W-1:0]    load_pc,
    output logic               valid,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    pc
);

    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0]    pc_q, pc_d;

    // Load wins over consume so a same-cycle refill produces no bubble.
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            instr_d = load_instr;
            pc_d    = load_pc;
        end else if (consume) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign valid = valid_q;
    assign instr = instr_q;
    assign pc    = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch front end: PC sequencing, single-outstanding imem reads,
// one-entry instruction buffer and taken-branch redirect with squash.
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned     PC_W     = PC_WIDTH,
    parameter int unsigned     INSTR_W  = INSTR_WIDTH,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int unsigned     CNT_W    = CNT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_out,
    output logic [PC_W-1:0]    instr_pc,
    input  logic               branch,
    input  logic               branch_res,
    input  logic [PC_W-1:0]    new_pc,
    output logic [CNT_W-1:0]   flush_count
);

    logic              started_q, started_d;
    logic              outstanding_q, outstanding_d;
    logic              drop_q, drop_d;
    logic [PC_W-1:0]   fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0]   pend_pc_q, pend_pc_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic consume, redirect, resp, buf_load;

    assign consume  = instr_valid & instr_ready;
    assign redirect = consume & branch & branch_res;
    assign resp     = imem_valid & outstanding_q;
    assign buf_load = resp & ~drop_q & ~redirect;

    assign imem_req    = started_q & ~outstanding_q & (~instr_valid | consume) & ~redirect;
    assign imem_addr   = fetch_pc_q;
    assign flush_count = flush_cnt_q;

    always_comb begin
        started_d     = 1'b1;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        fetch_pc_d    = fetch_pc_q;
        pend_pc_d     = pend_pc_q;
        flush_cnt_d   = flush_cnt_q;

        if (imem_req) begin
            outstanding_d = 1'b1;
            fetch_pc_d    = fetch_pc_q + 1'b1;
            pend_pc_d     = fetch_pc_q;
        end
        if (resp) begin
            outstanding_d = 1'b0;
            drop_d        = 1'b0;
        end
        // A wrong-path read still in flight must be swallowed when it lands.
        if (redirect) begin
            fetch_pc_d = new_pc;
            if (outstanding_q && !imem_valid) begin
                drop_d = 1'b1;
            end
            if (flush_cnt_q != '1) begin
                flush_cnt_d = flush_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started_q     <= 1'b0;
            outstanding_q <= 1'b0;
            drop_q        <= 1'b0;
            fetch_pc_q    <= RESET_PC;
            pend_pc_q     <= RESET_PC;
            flush_cnt_q   <= '0;
        end else begin
            started_q     <= started_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            fetch_pc_q    <= fetch_pc_d;
            pend_pc_q     <= pend_pc_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

    instr_buffer #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (buf_load),
        .consume    (consume),
        .flush      (redirect),
        .load_instr (imem_rdata),
        .load_pc    (pend_pc_q),
        .valid      (instr_valid),
        .instr      (instr_out),
        .pc         (instr_pc)
    );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized bench for fetch_sequencer against a program-order reference model.
module tb_fetch_sequencer;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, imem_req, imem_valid, instr_valid, instr_ready, branch, branch_res;
    logic [11:0] imem_addr, instr_pc, new_pc;
    logic [15:0] imem_rdata, instr_out;
    logic [7:0]  flush_count;

    logic        rst_w, imem_req_w, imem_valid_w, instr_valid_w, instr_ready_w, branch_w, branch_res_w;
    logic [11:0] imem_addr_w, instr_pc_w, new_pc_w;
    logic [15:0] imem_rdata_w, instr_out_w;
    logic [7:0]  flush_count_w;

    fetch_sequencer #(.PC_W(12), .INSTR_W(16), .RESET_PC(12'h000), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instr_out(instr_out), .instr_pc(instr_pc),
        .branch(branch), .branch_res(branch_res), .new_pc(new_pc), .flush_count(flush_count));

    fetch_sequencer #(.PC_W(12), .INSTR_W(16), .RESET_PC(12'hFFF), .CNT_W(8)) dut_w (
        .clk(clk), .rst_n(rst_w), .imem_req(imem_req_w), .imem_addr(imem_addr_w),
        .imem_valid(imem_valid_w), .imem_rdata(imem_rdata_w), .instr_valid(instr_valid_w),
        .instr_ready(instr_ready_w), .instr_out(instr_out_w), .instr_pc(instr_pc_w),
        .branch(branch_w), .branch_res(branch_res_w), .new_pc(new_pc_w), .flush_count(flush_count_w));

    int unsigned n_vec = 0, n_err = 0;

    // reference model state
    logic [11:0] exp_pc, exp_fetch, mem_addr;
    int unsigned m_flush, n_redir;
    bit          started_m, m_buf, m_drop, mem_pend;
    int          mem_cnt;
    int unsigned cyc, last_prog;
    bit          prev_held;
    logic [15:0] prev_out;
    logic [11:0] prev_pc;
    logic [11:0] req_addr_q[$];
    int unsigned req_cyc_q[$];
    logic [11:0] cons_pc_q[$];

    // stimulus controls
    int unsigned ready_pct, br_mode, lat_min, lat_max, hold_low;
    bit          dir_en, dir_taken;
    logic [11:0] dir_pc, dir_tgt;

    function automatic logic [15:0] mem_word(input logic [11:0] a);
        logic [15:0] t;
        if (a == 12'h003) return 16'h0A52;
        t = {4'h0, a} * 16'h9E37;
        return t ^ 16'h5C3A;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset(input bit late);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        imem_valid = 1'b0; instr_ready = 1'b0; branch = 1'b0; branch_res = 1'b0; new_pc = '0;
        #1;
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_imem_addr", 32'(imem_addr), 32'h000);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr_out", 32'(instr_out), 32'd0);
        chk("rst_instr_pc", 32'(instr_pc), 32'd0);
        chk("rst_flush_count", 32'(flush_count), 32'd0);
        exp_pc = 12'h000; exp_fetch = 12'h000; m_flush = 0; n_redir = 0;
        started_m = 0; m_buf = 0; m_drop = 0; mem_pend = 0; mem_cnt = 0;
        cyc = 0; last_prog = 0; prev_held = 0; hold_low = 0;
        req_addr_q.delete(); req_cyc_q.delete(); cons_pc_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        if (late) begin
            imem_valid = 1'b1;
            imem_rdata = 16'hDEAD;
        end
        #1;
        chk("release_no_req", 32'(imem_req), 32'd0);
        started_m = 1;
        @(posedge clk);
        #1;
        imem_valid = 1'b0;
        chk("stale_valid_ignored", 32'(instr_valid), 32'd0);
    endtask

    task automatic cycle();
        bit rdy, br, res, vdrive, cons, redir, accept, exp_req;
        logic [11:0] tgt;
        @(negedge clk);
        cyc++;
        vdrive = 0;
        if (mem_pend) begin
            mem_cnt--;
            if (mem_cnt <= 0) vdrive = 1;
        end
        imem_valid = vdrive;
        imem_rdata = vdrive ? mem_word(mem_addr) : 16'($urandom);
        if (hold_low > 0) begin
            rdy = 0;
            hold_low--;
        end else begin
            rdy = ($urandom_range(99) < ready_pct);
        end
        br  = 1'($urandom_range(1));
        res = 1'($urandom_range(1));
        tgt = 12'($urandom);
        if (br_mode == 0) begin
            br = 0;
        end else if (br_mode == 1) begin
            if (instr_valid) begin
                br  = (instr_opcode(instr_out) == OP_BRANCH);
                tgt = instr_target(instr_out);
            end
        end else begin
            br = 1; res = 1;
        end
        if (dir_en && instr_valid && instr_pc == dir_pc) begin
            br = 1; res = dir_taken; tgt = dir_tgt;
        end
        instr_ready = rdy; branch = br; branch_res = res; new_pc = tgt;
        #1;
        cons  = m_buf & rdy;
        redir = cons & br & res;

        chk("instr_valid", 32'(instr_valid), 32'(m_buf));
        chk("flush_count", 32'(flush_count), m_flush);
        exp_req = started_m && !mem_pend && (!m_buf || cons) && !redir;
        chk("imem_req", 32'(imem_req), 32'(exp_req));
        if (imem_req) chk("imem_addr", 32'(imem_addr), 32'(exp_fetch));
        if (m_buf) begin
            chk("instr_pc", 32'(instr_pc), 32'(exp_pc));
            chk("instr_out", 32'(instr_out), 32'(mem_word(exp_pc)));
        end
        if (prev_held) begin
            chk("hold_out", 32'(instr_out), 32'(prev_out));
            chk("hold_pc", 32'(instr_pc), 32'(prev_pc));
        end
        prev_held = m_buf & !cons;
        prev_out  = instr_out;
        prev_pc   = instr_pc;

        // model update: program order plus memory transaction bookkeeping
        accept = vdrive && !m_drop && !redir;
        if (cons) begin
            cons_pc_q.push_back(exp_pc);
            exp_pc = redir ? tgt : 12'(exp_pc + 12'd1);
            last_prog = cyc;
        end
        if (redir) begin
            n_redir++;
            m_flush = (m_flush == 255) ? 255 : m_flush + 1;
            exp_fetch = tgt;
            if (mem_pend && !vdrive) m_drop = 1;
        end
        if (vdrive) begin
            mem_pend = 0;
            m_drop = 0;
        end
        if (redir) m_buf = 0;
        else if (accept) m_buf = 1;
        else if (cons) m_buf = 0;
        if (imem_req) begin
            req_addr_q.push_back(imem_addr);
            req_cyc_q.push_back(cyc);
            exp_fetch = 12'(exp_fetch + 12'd1);
            mem_pend = 1;
            mem_addr = imem_addr;
            mem_cnt = int'($urandom_range(lat_max, lat_min));
        end
        if (cyc - last_prog > 60) begin
            n_vec++; n_err++;
            $display("FAIL progress_watchdog: no instruction consumed for %0d cycles", cyc - last_prog);
            last_prog = cyc;
        end
    endtask

    task automatic run(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) cycle();
    endtask

    task automatic chk_seq(input string name, input logic [11:0] q[$], input logic [11:0] exp[]);
        chk({name, "_len"}, 32'(q.size() >= exp.size()), 32'd1);
        if (q.size() >= exp.size())
            for (int i = 0; i < exp.size(); i++) chk(name, 32'(q[i]), 32'(exp[i]));
    endtask

    task automatic run_wrap();
        logic [11:0] a[$];
        logic [11:0] p[$];
        logic [11:0] pa;
        bit pend;
        pend = 0; pa = '0;
        rst_w = 1'b0;
        @(negedge clk);
        #1;
        chk("wrap_rst_addr", 32'(imem_addr_w), 32'hFFF);
        rst_w = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            imem_valid_w = pend;
            imem_rdata_w = pend ? mem_word(pa) : 16'h0000;
            #1;
            if (instr_valid_w) p.push_back(instr_pc_w);
            pend = 0;
            if (imem_req_w) begin
                a.push_back(imem_addr_w);
                pend = 1;
                pa = imem_addr_w;
            end
        end
        chk_seq("wrap_req_addr", a, '{12'hFFF, 12'h000});
        chk_seq("wrap_instr_pc", p, '{12'hFFF});
    endtask

    initial begin
        bit seen;
        int unsigned nreq, k;
        rst_n = 1'b0; imem_valid = 0; imem_rdata = '0; instr_ready = 0; branch = 0; branch_res = 0; new_pc = '0;
        rst_w = 1'b0; imem_valid_w = 0; imem_rdata_w = '0; instr_ready_w = 1; branch_w = 0; branch_res_w = 0; new_pc_w = '0;
        ready_pct = 100; br_mode = 0; lat_min = 1; lat_max = 1; dir_en = 0; dir_taken = 0; dir_pc = '0; dir_tgt = '0;

        // sequential fetch, latency 1
        do_reset(0);
        run(8);
        chk_seq("seq_req_addr", req_addr_q, '{12'h000, 12'h001, 12'h002});
        chk_seq("seq_instr_pc", cons_pc_q, '{12'h000, 12'h001, 12'h002});
        chk("seq_req_spacing0", req_cyc_q[1] - req_cyc_q[0], 32'd2);
        chk("seq_req_spacing1", req_cyc_q[2] - req_cyc_q[1], 32'd2);
        chk("seq_flush_count", 32'(flush_count), 32'd0);

        // backpressure with full buffer
        ready_pct = 0;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            cycle();
            seen = instr_valid;
        end
        chk("bp_buffer_full", 32'(seen), 32'd1);
        chk("bp_held_pc", 32'(instr_pc), 32'h003);
        nreq = req_addr_q.size();
        run(5);
        chk("bp_no_req", req_addr_q.size() - nreq, 32'd0);
        k = cons_pc_q.size();
        ready_pct = 100;
        run(6);
        chk_seq("bp_resume", cons_pc_q[k:$], '{12'h003, 12'h004});

        // taken branch at pc3
        do_reset(0);
        dir_en = 1; dir_pc = 12'h003; dir_taken = 1; dir_tgt = 12'h0A5;
        run(14);
        chk_seq("br_instr_pc", cons_pc_q, '{12'h000, 12'h001, 12'h002, 12'h003, 12'h0A5, 12'h0A6});
        chk_seq("br_req_addr", req_addr_q, '{12'h000, 12'h001, 12'h002, 12'h003, 12'h0A5});
        chk("br_redirect_gap", req_cyc_q[4] - req_cyc_q[3], 32'd3);
        chk("br_flush_count", 32'(flush_count), 32'd1);

        // redirect with latency 3
        do_reset(0);
        lat_min = 3; lat_max = 3;
        dir_pc = 12'h004; dir_tgt = 12'h123;
        run(34);
        chk_seq("l3_instr_pc", cons_pc_q, '{12'h000, 12'h001, 12'h002, 12'h003, 12'h004, 12'h123, 12'h124});
        chk_seq("l3_req_addr", req_addr_q, '{12'h000, 12'h001, 12'h002, 12'h003, 12'h004, 12'h123});
        chk("l3_req_spacing", req_cyc_q[1] - req_cyc_q[0], 32'd4);

        // not-taken branch at pc5
        do_reset(0);
        lat_min = 1; lat_max = 1;
        dir_pc = 12'h005; dir_taken = 0; dir_tgt = 12'h777;
        run(18);
        chk_seq("nt_instr_pc", cons_pc_q, '{12'h000, 12'h001, 12'h002, 12'h003, 12'h004, 12'h005, 12'h006});
        chk("nt_flush_count", 32'(flush_count), 32'd0);
        dir_en = 0;

        // randomized traffic, async reset mid-fetch with a stale response
        do_reset(0);
        br_mode = 1; ready_pct = 70; lat_min = 1; lat_max = 4;
        run(2000);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cycle();
            seen = mem_pend;
        end
        chk("midfetch_pending", 32'(seen), 32'd1);
        do_reset(1);
        run(1000);

        // saturation of the redirect counter
        do_reset(0);
        br_mode = 2; ready_pct = 100; lat_min = 1; lat_max = 1;
        run(1000);
        chk("sat_redirects_ge_300", 32'(n_redir >= 300), 32'd1);
        chk("sat_flush_count", 32'(flush_count), 32'd255);
        br_mode = 0;

        // wraparound from RESET_PC=0xFFF
        run_wrap();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
